// File: rtl/instruction_fetcher.sv
// instruction_fetcher
//   Front-end fetch stage. Holds the PC, looks it up in a direct-mapped
//   instruction cache (one 32-bit word per entry) and issues at most one
//   instruction per cycle to the decoder with a static next-PC prediction.
//   On a miss it requests the word from the memory controller and waits.
//   Back-end full signals stall issue; ROB rollback redirects the PC.
//
// Ports
//   clk_in, rst_in          clock (rising edge), async active-low reset
//   rob_full_in, rs_full_in,
//   lsb_full_in             back-end full flags; any of them stalls issue
//   rob_rollback_in/_pc_in  redirect request and target PC
//   mc_request_out/addr_out word request to memory controller, held until ready
//   mc_ready_in/data_in     one-cycle fill pulse with the fetched word
//   fet_issue_out           one-cycle pulse, fet_* valid
//   fet_inst_out/pc_out/
//   fet_predict_pc_out      issued instruction, its PC, predicted next PC
module instruction_fetcher #(
    parameter int          ICACHE_INDEX_BITS = 6,
    parameter logic [31:0] RESET_PC          = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rob_full_in,
    input  logic        rs_full_in,
    input  logic        lsb_full_in,
    input  logic        rob_rollback_in,
    input  logic [31:0] rob_rollback_pc_in,
    output logic        mc_request_out,
    output logic [31:0] mc_addr_out,
    input  logic        mc_ready_in,
    input  logic [31:0] mc_data_in,
    output logic        fet_issue_out,
    output logic [31:0] fet_inst_out,
    output logic [31:0] fet_pc_out,
    output logic [31:0] fet_predict_pc_out
);

    localparam int ENTRIES  = 1 << ICACHE_INDEX_BITS;
    localparam int TAG_BITS = 32 - ICACHE_INDEX_BITS - 2;

    typedef enum logic {
        FETCH,
        MISS
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0] pc;
    logic [31:0] miss_addr;

    logic [ENTRIES-1:0]  cache_valid;
    logic [TAG_BITS-1:0] cache_tag  [ENTRIES];
    logic [31:0]         cache_data [ENTRIES];

    logic [ICACHE_INDEX_BITS-1:0] pc_index;
    logic [TAG_BITS-1:0]          pc_tag;
    logic [ICACHE_INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]          fill_tag;
    logic                         hit;
    logic [31:0]                  hit_word;
    logic                         stall;

    logic [31:0] imm_j;
    logic [31:0] imm_b;
    logic [31:0] predict_pc;

    logic issue_en;
    logic start_miss;
    logic fill_en;

    assign pc_index   = pc[ICACHE_INDEX_BITS+1:2];
    assign pc_tag     = pc[31:ICACHE_INDEX_BITS+2];
    assign fill_index = miss_addr[ICACHE_INDEX_BITS+1:2];
    assign fill_tag   = miss_addr[31:ICACHE_INDEX_BITS+2];
    assign hit        = cache_valid[pc_index] && (cache_tag[pc_index] == pc_tag);
    assign hit_word   = cache_data[pc_index];
    assign stall      = rob_full_in | rs_full_in | lsb_full_in;

    // Static prediction: JAL always taken, branches taken only when the
    // offset is negative (loop back-edges), everything else falls through.
    always_comb begin
        imm_j = {{12{hit_word[31]}}, hit_word[19:12], hit_word[20], hit_word[30:21], 1'b0};
        imm_b = {{20{hit_word[31]}}, hit_word[7], hit_word[30:25], hit_word[11:8], 1'b0};
        predict_pc = pc + 32'd4;
        if (hit_word[6:0] == 7'h6F) begin
            predict_pc = pc + imm_j;
        end else if (hit_word[6:0] == 7'h63 && imm_b[31]) begin
            predict_pc = pc + imm_b;
        end
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A rollback in FETCH keeps us in FETCH so the new PC
    // is looked up first; a rollback in MISS does not cancel the fill.
    always_comb begin
        state_next = state;
        case (state)
            FETCH: if (!rob_rollback_in && !hit) state_next = MISS;
            MISS:  if (mc_ready_in)              state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // Per-cycle control decoded from state and inputs.
    always_comb begin
        issue_en   = 1'b0;
        start_miss = 1'b0;
        fill_en    = 1'b0;
        case (state)
            FETCH: begin
                issue_en   = !rob_rollback_in && hit && !stall;
                start_miss = !rob_rollback_in && !hit;
            end
            MISS: fill_en = mc_ready_in;
            default: ;
        endcase
    end

    // PC, memory request and issue registers. Rollback overrides the PC in
    // either state; issue_en is already suppressed when a rollback is seen.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pc                 <= RESET_PC;
            miss_addr          <= 32'h0;
            mc_request_out     <= 1'b0;
            fet_issue_out      <= 1'b0;
            fet_inst_out       <= 32'h0;
            fet_pc_out         <= 32'h0;
            fet_predict_pc_out <= 32'h0;
        end else begin
            fet_issue_out <= issue_en;
            if (rob_rollback_in) begin
                pc <= rob_rollback_pc_in;
            end else if (issue_en) begin
                pc <= predict_pc;
            end
            if (issue_en) begin
                fet_inst_out       <= hit_word;
                fet_pc_out         <= pc;
                fet_predict_pc_out <= predict_pc;
            end
            if (start_miss) begin
                miss_addr      <= {pc[31:2], 2'b00};
                mc_request_out <= 1'b1;
            end else if (fill_en) begin
                mc_request_out <= 1'b0;
            end
        end
    end

    assign mc_addr_out = miss_addr;

    // Valid bits need reset; tag and data arrays are qualified by them.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cache_valid <= '0;
        end else if (fill_en) begin
            cache_valid[fill_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            cache_tag[fill_index]  <= fill_tag;
            cache_data[fill_index] <= mc_data_in;
        end
    end

endmodule

// File: tb/tb_instruction_fetcher.sv
// tb_instruction_fetcher
//   Directed, self-checking bench for instruction_fetcher. Inputs change and
//   outputs are sampled 1 ns after each rising edge. Scenario tasks run in a
//   fixed order and share the cache contents built up along the way.
module tb_instruction_fetcher;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rob_full = 1'b0;
    logic        rs_full = 1'b0;
    logic        lsb_full = 1'b0;
    logic        rollback = 1'b0;
    logic [31:0] rollback_pc = 32'h0;
    logic        mc_request;
    logic [31:0] mc_addr;
    logic        mc_ready = 1'b0;
    logic [31:0] mc_data = 32'h0;
    logic        issue;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic [31:0] predict;

    int checks   = 0;
    int failures = 0;

    instruction_fetcher dut (
        .clk_in             (clk),
        .rst_in             (rst),
        .rob_full_in        (rob_full),
        .rs_full_in         (rs_full),
        .lsb_full_in        (lsb_full),
        .rob_rollback_in    (rollback),
        .rob_rollback_pc_in (rollback_pc),
        .mc_request_out     (mc_request),
        .mc_addr_out        (mc_addr),
        .mc_ready_in        (mc_ready),
        .mc_data_in         (mc_data),
        .fet_issue_out      (issue),
        .fet_inst_out       (inst),
        .fet_pc_out         (pc_out),
        .fet_predict_pc_out (predict)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (mc_request !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%b exp=0", mc_request); end
        checks++; if (issue !== 1'b0) begin failures++; $display("[TB] FAIL reset_issue got=%b exp=0", issue); end
        checks++; if (mc_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr got=%h exp=0", mc_addr); end
        checks++; if ({inst, pc_out, predict} !== 96'h0) begin failures++; $display("[TB] FAIL reset_fet got=%h/%h/%h exp=0", inst, pc_out, predict); end
        rst = 1'b1;
        tick();
        checks++; if (mc_request !== 1'b1) begin failures++; $display("[TB] FAIL first_req got=%b exp=1", mc_request); end
        checks++; if (mc_addr !== 32'h0) begin failures++; $display("[TB] FAIL first_addr got=%h exp=0", mc_addr); end
        checks++; if (issue !== 1'b0) begin failures++; $display("[TB] FAIL first_issue got=%b exp=0", issue); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (mc_request !== 1'b1 || mc_addr !== 32'h0) begin failures++; $display("[TB] FAIL hold_req got=%b/%h exp=1/0", mc_request, mc_addr); end
        end
        mc_ready = 1'b1; mc_data = 32'h0000_0013;
        tick();
        mc_ready = 1'b0;
        checks++; if (mc_request !== 1'b0 || issue !== 1'b0) begin failures++; $display("[TB] FAIL fill_drop got=%b/%b exp=0/0", mc_request, issue); end
        tick();
        checks++; if (issue !== 1'b1) begin failures++; $display("[TB] FAIL fill_issue got=%b exp=1", issue); end
        checks++; if (inst !== 32'h13 || pc_out !== 32'h0 || predict !== 32'h4) begin failures++; $display("[TB] FAIL fill_fet got=%h/%h/%h exp=13/0/4", inst, pc_out, predict); end
        tick();
        checks++; if (mc_request !== 1'b1 || mc_addr !== 32'h4 || issue !== 1'b0) begin failures++; $display("[TB] FAIL next_miss got=%b/%h/%b exp=1/4/0", mc_request, mc_addr, issue); end
    endtask

    task automatic test_rollback_miss();
        rollback = 1'b1; rollback_pc = 32'h40;
        tick();
        rollback = 1'b0;
        checks++; if (mc_request !== 1'b1 || mc_addr !== 32'h4 || issue !== 1'b0) begin failures++; $display("[TB] FAIL rb_miss_hold got=%b/%h/%b exp=1/4/0", mc_request, mc_addr, issue); end
        mc_ready = 1'b1; mc_data = 32'h0000_0013;
        tick();
        mc_ready = 1'b0;
        checks++; if (mc_request !== 1'b0 || issue !== 1'b0) begin failures++; $display("[TB] FAIL rb_fill got=%b/%b exp=0/0", mc_request, issue); end
        tick();
        checks++; if (mc_request !== 1'b1 || mc_addr !== 32'h40 || issue !== 1'b0) begin failures++; $display("[TB] FAIL rb_newpc got=%b/%h/%b exp=1/40/0", mc_request, mc_addr, issue); end
        mc_ready = 1'b1; mc_data = 32'h0000_0013;
        tick();
        mc_ready = 1'b0;
        tick();
        checks++; if (issue !== 1'b1 || pc_out !== 32'h40 || predict !== 32'h44) begin failures++; $display("[TB] FAIL rb_issue got=%b/%h/%h exp=1/40/44", issue, pc_out, predict); end
        tick();
        checks++; if (mc_request !== 1'b1 || mc_addr !== 32'h44) begin failures++; $display("[TB] FAIL rb_next got=%b/%h exp=1/44", mc_request, mc_addr); end
    endtask

    task automatic test_jal();
        // Rollback and fill in the same cycle: fill goes to 0x44, pc to 0x10.
        rollback = 1'b1; rollback_pc = 32'h10; mc_ready = 1'b1; mc_data = 32'h0000_0013;
        tick();
        rollback = 1'b0; mc_ready = 1'b0;
        checks++; if (mc_request !== 1'b0 || issue !== 1'b0) begin failures++; $display("[TB] FAIL both_drop got=%b/%b exp=0/0", mc_request, issue); end
        tick();
        checks++; if (mc_request !== 1'b1 || mc_addr !== 32'h10) begin failures++; $display("[TB] FAIL jal_req got=%b/%h exp=1/10", mc_request, mc_addr); end
        mc_ready = 1'b1; mc_data = 32'h0080_006F;
        tick();
        mc_ready = 1'b0;
        tick();
        checks++; if (issue !== 1'b1 || inst !== 32'h0080_006F || pc_out !== 32'h10 || predict !== 32'h18) begin failures++; $display("[TB] FAIL jal_issue got=%b/%h/%h/%h exp=1/0080006f/10/18", issue, inst, pc_out, predict); end
        tick();
        checks++; if (mc_request !== 1'b1 || mc_addr !== 32'h18 || issue !== 1'b0) begin failures++; $display("[TB] FAIL jal_target got=%b/%h/%b exp=1/18/0", mc_request, mc_addr, issue); end
    endtask

    task automatic test_branch();
        rollback = 1'b1; rollback_pc = 32'h20; mc_ready = 1'b1; mc_data = 32'h0000_0013;
        tick();
        rollback = 1'b0; mc_ready = 1'b0;
        tick();
        checks++; if (mc_request !== 1'b1 || mc_addr !== 32'h20) begin failures++; $display("[TB] FAIL beq_req got=%b/%h exp=1/20", mc_request, mc_addr); end
        mc_ready = 1'b1; mc_data = 32'hFE00_0CE3;
        tick();
        mc_ready = 1'b0;
        tick();
        checks++; if (issue !== 1'b1 || pc_out !== 32'h20 || predict !== 32'h18) begin failures++; $display("[TB] FAIL beq_issue got=%b/%h/%h exp=1/20/18", issue, pc_out, predict); end
        tick();
        checks++; if (issue !== 1'b1 || inst !== 32'h13 || pc_out !== 32'h18 || predict !== 32'h1C) begin failures++; $display("[TB] FAIL beq_target got=%b/%h/%h/%h exp=1/13/18/1c", issue, inst, pc_out, predict); end
        tick();
        checks++; if (mc_request !== 1'b1 || mc_addr !== 32'h1C || issue !== 1'b0) begin failures++; $display("[TB] FAIL beq_next got=%b/%h/%b exp=1/1c/0", mc_request, mc_addr, issue); end
    endtask

    task automatic test_stall();
        logic [2:0] pattern [6];
        pattern = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001};
        rollback = 1'b1; rollback_pc = 32'h0; mc_ready = 1'b1; mc_data = 32'h0000_0013;
        tick();
        rollback = 1'b0; mc_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            {rob_full, rs_full, lsb_full} = pattern[i];
            tick();
            checks++; if (issue !== 1'b0 || mc_request !== 1'b0 || pc_out !== 32'h18) begin failures++; $display("[TB] FAIL stall_%0d got=%b/%b/%h exp=0/0/18", i, issue, mc_request, pc_out); end
        end
        {rob_full, rs_full, lsb_full} = 3'b000;
        tick();
        checks++; if (issue !== 1'b1 || pc_out !== 32'h0 || predict !== 32'h4) begin failures++; $display("[TB] FAIL stall_release got=%b/%h/%h exp=1/0/4", issue, pc_out, predict); end
    endtask

    task automatic test_back_to_back();
        tick();
        checks++; if (issue !== 1'b1 || inst !== 32'h13 || pc_out !== 32'h4 || predict !== 32'h8) begin failures++; $display("[TB] FAIL b2b_issue got=%b/%h/%h/%h exp=1/13/4/8", issue, inst, pc_out, predict); end
        tick();
        checks++; if (issue !== 1'b0 || mc_request !== 1'b1 || mc_addr !== 32'h8) begin failures++; $display("[TB] FAIL b2b_miss got=%b/%b/%h exp=0/1/8", issue, mc_request, mc_addr); end
    endtask

    task automatic test_async_reset();
        #3;
        rst = 1'b0;
        #1;
        checks++; if (mc_request !== 1'b0 || issue !== 1'b0 || mc_addr !== 32'h0) begin failures++; $display("[TB] FAIL async_rst got=%b/%b/%h exp=0/0/0", mc_request, issue, mc_addr); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (mc_request !== 1'b1 || mc_addr !== 32'h0 || issue !== 1'b0) begin failures++; $display("[TB] FAIL cache_cleared got=%b/%h/%b exp=1/0/0", mc_request, mc_addr, issue); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_rollback_miss();
        test_jal();
        test_branch();
        test_stall();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
